rr_reg_arbiter: RTL and testbench
=================================

RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, shared register width.
REQ-003 Parameter MAX_HOLD, default 4, max consecutive grant cycles when others wait (>=1).
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset, sampled only on posedge clock.
REQ-006 req    input  N_REQ  per-requester request, level-held until done.
REQ-007 wdata  input  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 gnt    output N_REQ  registered one-hot grant, or all-zero.
REQ-009 q      output WIDTH  shared D-register contents.
REQ-010 owner  output ceil(log2 N_REQ)  index of current or last grantee.
REQ-011 busy   output 1  high while in GRANT state.

Function
REQ-012 The block SHALL have two states: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-013 IDLE: if any req at posedge -> GRANT, gnt set to the winner; else stay IDLE.
REQ-014 The winner SHALL be the first asserted req searching from (owner+1) mod N_REQ upward, with wrap.
REQ-015 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to gnt high.
REQ-016 At each posedge where gnt[i]=1 and req[i]=1, q SHALL load wdata slice i; otherwise q holds.
REQ-017 hold_cnt SHALL clear to 0 on every new grant and increment on each GRANT cycle.
REQ-018 Release condition: req[owner]=0, OR hold_cnt=MAX_HOLD-1 with another req pending.
REQ-019 On release: if another req is pending -> gnt moves directly to the RR winner excluding owner (no idle cycle), owner updates, hold_cnt=0.
REQ-020 On release with none pending and req[owner]=0 -> IDLE, gnt=0, owner holds.
REQ-021 hold_cnt reaching MAX_HOLD-1 with no other req pending: grant kept, hold_cnt wraps to 0.
REQ-022 gnt SHALL never have more than one bit set; gnt[i] SHALL never rise when req[i]=0 at that edge.
REQ-023 A requester dropping and re-raising req SHALL compete again via RR; no queued history is kept.
REQ-024 Any requester continuously requesting SHALL be granted within (N_REQ-1)*MAX_HOLD+1 cycles.

Reset
REQ-025 While reset=1 at posedge: state=IDLE, gnt=0, q=0, busy=0, hold_cnt=0, owner=N_REQ-1 (req0 first priority).
REQ-026 Reset SHALL take priority over all other conditions, including mid-grant and mid-write; no write happens that edge.
REQ-027 Outputs SHALL NOT change asynchronously on reset; change only at clock edges.

Structure
REQ-028 State encoding and default parameter constants SHALL live in the shared package rr_arb_pkg.
REQ-029 The RR winner search SHALL be a combinational sub-module rr_pick (inputs: request mask, start index; outputs: one-hot, index, valid).
REQ-030 The shared register SHALL be a single WIDTH-bit D-register with sync reset inside rr_reg_arbiter.

Verification
REQ-031 Reset: reset=1 for 2 cycles with req=4'b1111 -> gnt=0, q=0, busy=0 throughout; first grant after release is gnt=4'b0001.
REQ-032 Single requester: req=4'b0100, wdata slice2=8'hA5 -> gnt=4'b0100 next cycle, q=8'hA5 the following edge, busy=1.
REQ-033 Round robin: req=4'b1111 held, MAX_HOLD=4 -> grants 0,1,2,3,0 each exactly 4 cycles, back-to-back, no idle gap.
REQ-034 Early release: owner 1 drops req after 2 cycles, req3 pending -> gnt=4'b1000 next edge, q stops loading slice1.
REQ-035 No contention: req=4'b0010 held 10 cycles alone -> gnt stays 4'b0010, hold_cnt wraps, q tracks slice1 every cycle.
REQ-036 Reset mid-grant: reset=1 while gnt=4'b0100 -> next edge gnt=0, q=0, owner=3; assertion checks one-hot gnt every cycle.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin register arbiter.
package rr_arb_pkg;

  localparam int unsigned DefNReq    = 4;
  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefMaxHold = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of mask at or after start, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         mask,
  input  logic [$clog2(N_REQ)-1:0] start,
  output logic [N_REQ-1:0]         onehot,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic [IdxW-1:0] j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      // Modulo keeps the wrap correct for non-power-of-two requester counts.
      j = IdxW'((int'(start) + k) % int'(N_REQ));
      if (!valid && mask[j]) begin
        valid     = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared register,
// with a bounded hold time whenever other requesters are waiting.
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = DefNReq,
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned MAX_HOLD = DefMaxHold
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int unsigned IdxW  = $clog2(N_REQ);
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] pick_mask;
  logic [IdxW-1:0]  pick_start;
  logic [N_REQ-1:0] pick_oh;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             at_limit;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  // While granting, the current owner is masked so pick_valid means "someone else waits".
  assign pick_mask  = (state_q == StGrant) ? (req & ~owner_oh) : req;
  assign pick_start = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_req  = req[owner_q];
  assign at_limit   = (hold_q == HoldW'(MAX_HOLD - 1));

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .mask   (pick_mask),
    .start  (pick_start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    q_d     = q_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (owner_req) begin
          q_d = wdata[owner_q*WIDTH +: WIDTH];
        end
        if ((!owner_req || at_limit) && pick_valid) begin
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          hold_d  = '0;
        end else if (!owner_req) begin
          state_d = StIdle;
          gnt_d   = '0;
          hold_d  = '0;
        end else if (at_limit) begin
          hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= IdxW'(N_REQ - 1);
      hold_q  <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign q     = q_q;
  assign owner = owner_q;
  assign busy  = (state_q == StGrant);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed and randomized bench for rr_reg_arbiter, checked against a behavioural model.
module tb_rr_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;
  localparam int Bound = (N - 1) * MH + 1;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [1:0]     owner;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit     m_busy;
  int     m_owner;
  int     m_hold;
  bit [W-1:0] m_q;
  int     waits [N];

  rr_reg_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_HOLD (MH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    checks++;
    assert ($onehot0(gnt)) else begin
      errors++;
      $error("FAIL gnt_onehot observed=%b expected=at most one bit", gnt);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester after 'from' in circular order, skipping 'excl'; -1 when none.
  function automatic int winner(input logic [N-1:0] r, input int from, input int excl);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (from + k) % N;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic bit [W-1:0] slice(input logic [N*W-1:0] d, input int i);
    return d[i*W +: W];
  endfunction

  task automatic model_edge();
    int w;
    if (reset) begin
      m_busy = 0; m_owner = N - 1; m_hold = 0; m_q = '0;
    end else if (!m_busy) begin
      w = winner(req, m_owner, -1);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_hold = 0;
      end
    end else begin
      if (req[m_owner]) m_q = slice(wdata, m_owner);
      w = winner(req, m_owner, m_owner);
      if ((!req[m_owner] || m_hold == MH - 1) && w >= 0) begin
        m_owner = w; m_hold = 0;
      end else if (!req[m_owner]) begin
        m_busy = 0; m_hold = 0;
      end else begin
        m_hold = (m_hold + 1) % MH;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_gnt;
    logic [N-1:0] req_seen;
    @(posedge clock);
    req_seen = req;
    model_edge();
    #1;
    exp_gnt = m_busy ? N'(1 << m_owner) : '0;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("q", 32'(q), 32'(m_q));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_busy));
    for (int i = 0; i < N; i++) begin
      if (reset || !req_seen[i] || gnt[i]) waits[i] = 0;
      else waits[i]++;
      if (waits[i] > 0) chk("starvation", 32'(waits[i] <= Bound), 32'd1);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] s1;
    reset = 1'b1;
    req   = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    m_busy = 0; m_owner = N - 1; m_hold = 0; m_q = '0;

    // Reset with all requests raised; first grant goes to requester 0.
    req = 4'b1111;
    wdata = 32'h44332211;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    step();
    chk("first_gnt", 32'(gnt), 32'b0001);

    // Single requester
    do_reset(1);
    req = 4'b0100;
    wdata = 32'h00A50000;
    step();
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_busy", 32'(busy), 32'd1);
    step();
    chk("single_q", 32'(q), 32'hA5);

    // Full round robin, four cycles each
    do_reset(1);
    req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      wdata = {$urandom, $urandom};
      step();
      chk("rr_gnt", 32'(gnt), 32'(1 << (((k - 1) / 4) % 4)));
    end

    // Early release by owner 1 with requester 3 pending
    do_reset(1);
    req = 4'b1010;
    wdata = 32'h3D00_1C00;
    step();
    chk("early_gnt1", 32'(gnt), 32'b0010);
    step();
    step();
    s1 = 8'h1C;
    req = 4'b1000;
    wdata = 32'h3E00_7700;
    step();
    chk("early_gnt3", 32'(gnt), 32'b1000);
    chk("early_q", 32'(q), 32'(s1));
    step();
    chk("early_q3", 32'(q), 32'h3E);

    // Lone requester keeps the grant through hold-counter wraps
    do_reset(1);
    req = 4'b0010;
    wdata = {$urandom, $urandom};
    step();
    for (int k = 0; k < 10; k++) begin
      s1 = 8'($urandom);
      wdata = {16'($urandom), s1, 8'($urandom)};
      step();
      chk("alone_gnt", 32'(gnt), 32'b0010);
      chk("alone_q", 32'(q), 32'(s1));
    end

    // Reset in the middle of a grant
    do_reset(1);
    req = 4'b0100;
    wdata = 32'h00990000;
    step();
    step();
    chk("mid_gnt", 32'(gnt), 32'b0100);
    reset = 1'b1;
    step();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd3);
    reset = 1'b0;

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      wdata = {$urandom, $urandom};
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
